muldiv: RTL and testbench

Iterative 32-bit multiply/divide unit. It computes MULT/MULTU/DIV/DIVU on the HI/LO register pair, which the single-cycle ALU does not provide. It sits beside the ALU in the execute stage. The pipeline starts an operation, stalls on `busy` only when HI/LO are read, and reads HI/LO directly.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv.sv | 166 ++++++++++++++++
 tb/tb_muldiv.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings, FSM states and constants for the iterative
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings as supplied by the decoder
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } state_t;

    // One iteration per operand bit
    localparam int MD_ITERS = 32;

    // Quotient reported for any divide by zero
    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the shift-add multiplier or
//               the restoring divider on a shared (2*XLEN+1)-bit accumulator.
//               Multiply layout : {partial[XLEN:0], multiplier[XLEN-1:0]}
//               Divide layout   : {remainder[XLEN:0], quotient[XLEN-1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN:0]  i_acc,
    input  logic [XLEN-1:0]  i_operand,
    input  logic             i_is_div,
    output logic [2*XLEN:0]  o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_shifted;
    logic [XLEN+1:0] w_diff;

    // Select the multiply or divide update of the accumulator
    always_comb begin
        // Multiply: add multiplicand into the upper part when the multiplier
        // LSB is set; the shift right is folded into the concatenation.
        w_sum         = i_acc[2*XLEN:XLEN] + {1'b0, i_operand};
        // Divide: the remainder after the left shift is acc[2*XLEN-1:XLEN-1];
        // one extra MSB on the difference acts as the borrow flag.
        w_rem_shifted = i_acc[2*XLEN-1:XLEN-1];
        w_diff        = {1'b0, w_rem_shifted} - {2'b00, i_operand};

        if (i_is_div) begin
            if (w_diff[XLEN+1]) begin
                o_acc = {i_acc[2*XLEN-1:0], 1'b0};
            end else begin
                o_acc = {w_diff[XLEN:0], i_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc = {1'b0, w_sum, i_acc[XLEN-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*XLEN:1]};
            end
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv
// Description : Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO
//               register pair. Accept edge to result: 33 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int                 c_acc_w     = 2*XLEN + 1;
    localparam int                 c_cnt_w     = $clog2(MD_ITERS);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(MD_ITERS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_acc_next;
    logic [XLEN-1:0]    r_operand;
    logic [XLEN-1:0]    r_a_raw;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div0;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_signed;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_hi_fix;
    logic [XLEN-1:0]    w_lo_fix;

    assign w_accept = (r_state == IDLE) && start;
    assign w_signed = ~op[0];
    // Magnitudes fit in XLEN unsigned bits, including |-2^(XLEN-1)|
    assign w_abs_a  = (w_signed && A[XLEN-1]) ? -A : A;
    assign w_abs_b  = (w_signed && B[XLEN-1]) ? -B : B;

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_is_div  (r_is_div),
        .o_acc     (w_acc_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> CALC (32 iterations) -> FIXUP -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC:    if (r_count == c_last_iter) w_state_next = FIXUP;
            FIXUP:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture on accept, one accumulator iteration per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_a_raw   <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_is_div  <= op[1];
            r_sign_a  <= w_signed & A[XLEN-1];
            r_sign_b  <= w_signed & B[XLEN-1];
            r_a_raw   <= A;
            r_div0    <= (B == '0);
            r_operand <= op[1] ? w_abs_b : w_abs_a;
            r_acc     <= {{(XLEN+1){1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
        end else if (r_state == CALC) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + c_cnt_one;
        end
    end

    assign w_prod     = r_acc[2*XLEN-1:0];
    // Sign flags are only ever set for signed ops, so no op check is needed
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quot     = r_acc[XLEN-1:0];
    assign w_rem      = r_acc[2*XLEN-1:XLEN];

    // Sign correction and divide-by-zero override of the raw result
    always_comb begin
        w_hi_fix = w_prod_fix[2*XLEN-1:XLEN];
        w_lo_fix = w_prod_fix[XLEN-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_hi_fix = r_a_raw;
                w_lo_fix = DIV0_LO;
            end else begin
                w_lo_fix = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
                w_hi_fix = r_sign_a ? -w_rem : w_rem;
            end
        end
    end

    // HI/LO: result write in FIXUP, MTHI/MTLO only when idle and not starting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FIXUP);
            if (r_state == FIXUP) begin
                r_hi <= w_hi_fix;
                r_lo <= w_lo_fix;
            end else if ((r_state == IDLE) && !start) begin
                if (wr_hi) r_hi <= wdata;
                if (wr_lo) r_lo <= wdata;
            end
        end
    end

endmodule : muldiv
`default_nettype wire

// File: tb/tb_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv
// Description : Self-checking bench for muldiv against a plain-arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: {HI,LO} from ordinary integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, tq, tr, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (o)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = ua * ub;
            default: begin
                if (b == 32'b0) begin
                    res = {a, 32'hFFFFFFFF};
                end else if (o == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    tq = 64'(q);
                    tr = 64'(r);
                    res = {tr[31:0], tq[31:0]};
                end else begin
                    tq = ua / ub;
                    tr = ua % ub;
                    res = {tr[31:0], tq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'h80000000;
            4:       v = 32'h7FFFFFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One operation: accept, latency, busy/hold behaviour and the result
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic do_wr, input string tag);
        logic [63:0] exp;
        logic [31:0] prev_hi, prev_lo;
        int          cyc;
        logic        busy_ok, hold_ok;
        exp = model(o, a, b);
        @(negedge clk);
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; op = o; A = a; B = b;
        if (do_wr) begin
            wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5A5A5A5A;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        check($sformatf("%s.busy_after_accept", tag), 32'(busy), 32'd1);
        cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
            if (!done && (hi !== prev_hi || lo !== prev_lo)) hold_ok = 1'b0;
        end
        check($sformatf("%s.latency", tag), 32'(cyc), 32'd33);
        check($sformatf("%s.busy_held", tag), 32'(busy_ok), 32'd1);
        check($sformatf("%s.hilo_held", tag), 32'(hold_ok), 32'd1);
        check($sformatf("%s.busy_in_done", tag), 32'(busy), 32'd0);
        check($sformatf("%s.hi", tag), hi, exp[63:32]);
        check($sformatf("%s.lo", tag), lo, exp[31:0]);
    endtask

    initial begin
        int n_done;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        check("multu_max.hi_const", hi, 32'hFFFFFFFE);
        check("multu_max.lo_const", lo, 32'h00000001);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        1'b0, "mult_neg3x5");
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 1'b0, "mult_min_sq");
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, "div_m7_2");
        run_op(OP_DIVU,  32'd7,        32'd2,        1'b0, "divu_7_2");
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        check("div_ovf.lo_const", lo, 32'h80000000);
        run_op(OP_DIVU,  32'h12345678, 32'd0,        1'b0, "divu_by0");
        run_op(OP_DIV,   32'hFFFFFFFB, 32'd0,        1'b0, "div_m5_by0");
        check("div_m5_by0.hi_const", hi, 32'hFFFFFFFB);
        // Write in the same cycle as an accepted start is dropped
        run_op(OP_MULTU, 32'd2,        32'd3,        1'b1, "start_wins");

        // start and wr_lo while busy are ignored
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd3; wr_lo = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        check("busy_ignore.done_seen", 32'(done), 32'd1);
        check("busy_ignore.hi", hi, 32'd0);
        check("busy_ignore.lo", lo, 32'd12);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("busy_ignore.no_second_done", 32'(n_done), 32'd0);
        check("busy_ignore.lo_after", lo, 32'd12);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIV, 32'd100, 32'd7, 1'b0, "div_100_7");
        check("div_100_7.lo_const", lo, 32'd14);
        check("div_100_7.hi_const", hi, 32'd2);

        // MTHI / MTLO in idle
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hCAFEBABE;
        #1;
        check("mthi.before_edge", hi, 32'd2);
        @(posedge clk); #1;
        wr_hi = 1'b0;
        check("mthi.hi", hi, 32'hCAFEBABE);
        check("mthi.done", 32'(done), 32'd0);
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'h1;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        check("mtlo.lo", lo, 32'h1);
        check("mtlo.hi_kept", hi, 32'hCAFEBABE);
        check("mtlo.done", 32'(done), 32'd0);

        // Randomized operations, issued back to back
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_muldiv
`default_nettype wire
